// File: rtl/hdbn_pkg.sv
// Shared constants and helpers for the HDBn line encoder.
package hdbn_pkg;

  // Kind of each buffered / emitted symbol
  localparam logic [1:0] KIND_ZERO = 2'b00;
  localparam logic [1:0] KIND_MARK = 2'b01;
  localparam logic [1:0] KIND_B    = 2'b10;
  localparam logic [1:0] KIND_V    = 2'b11;

  // Signed ternary line code; 2'b10 is never produced
  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_POS  = 2'b01;
  localparam logic [1:0] CODE_NEG  = 2'b11;

  // Map a symbol kind plus its resolved polarity (1 = positive) to a line code.
  function automatic logic [1:0] kind_to_code(input logic [1:0] kind, input logic pol);
    if (kind == KIND_ZERO) begin
      return CODE_ZERO;
    end
    return pol ? CODE_POS : CODE_NEG;
  endfunction

endpackage

// File: rtl/hdbn_encoder_if.sv
// Bit-stream interface of the HDBn encoder.
//
// Handshake: there is no ready/backpressure. A beat is transferred on every
// rising clk edge where in_valid=1; in_data is ignored otherwise. out_valid
// is a one-cycle pulse qualifying out_code/out_kind; when out_valid=0 both
// out_code and out_kind read 2'b00.
interface hdbn_encoder_if;
  logic       in_valid;
  logic       in_data;
  logic       out_valid;
  logic [1:0] out_code;
  logic [1:0] out_kind;

  // NRZ source / line-driver side
  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_code,
    input  out_kind
  );

  // Encoder side
  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_code,
    output out_kind
  );
endinterface

// File: rtl/hdbn_polarity.sv
// Output stage: assigns AMI polarity to each symbol leaving the delay line
// and registers the line code. V pulses repeat the previous mark's polarity.
module hdbn_polarity
  import hdbn_pkg::*;
#(
  parameter int FIRST_POS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       emit,
  input  logic [1:0] kind,
  output logic       out_valid,
  output logic [1:0] out_code,
  output logic [1:0] out_kind
);

  // 1 = last mark was positive
  logic last_pol_q;
  logic pol;

  // Polarity for the symbol being emitted: alternate for marks/B, repeat for V
  always_comb begin
    pol = ~last_pol_q;
    if (kind == KIND_V) begin
      pol = last_pol_q;
    end
  end

  // Register the code/kind and track the polarity of the last mark
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_code   <= CODE_ZERO;
      out_kind   <= KIND_ZERO;
      last_pol_q <= (FIRST_POS == 0);
    end else if (emit) begin
      out_valid <= 1'b1;
      out_code  <= kind_to_code(kind, pol);
      out_kind  <= kind;
      if (kind == KIND_MARK || kind == KIND_B) begin
        last_pol_q <= pol;
      end
    end else begin
      out_valid <= 1'b0;
      out_code  <= CODE_ZERO;
      out_kind  <= KIND_ZERO;
    end
  end

endmodule

// File: rtl/hdbn_encoder.sv
// HDBn line encoder (HDB3 with N_ZERO=3). An N_ZERO+1 deep delay line holds
// symbol kinds so that, when the (N_ZERO+1)th consecutive zero arrives, the
// first zero of the run is still buffered and can be rewritten to a B pulse.
// Legal N_ZERO range is 2..7.
module hdbn_encoder
  import hdbn_pkg::*;
#(
  parameter int N_ZERO    = 3,
  parameter int FIRST_POS = 1
) (
  input  logic          clk,
  input  logic          rst,
  hdbn_encoder_if.slave bus
);

  localparam int DEPTH = N_ZERO + 1;
  localparam int ZW    = $clog2(N_ZERO + 1);
  localparam int FW    = $clog2(DEPTH + 1);
  localparam logic [ZW-1:0] ZCNT_MAX  = ZW'(N_ZERO);
  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);

  // Index 0 is the newest entry, DEPTH-1 the oldest (next to leave)
  logic [DEPTH-1:0][1:0] line_q;
  logic [DEPTH-1:0][1:0] line_d;
  logic [FW-1:0]         fill_q;
  logic [ZW-1:0]         zero_cnt_q;
  logic                  parity_q;   // 0 = even number of marks since last V

  logic       accept;
  logic       subst;
  logic       full;
  logic       emit;
  logic [1:0] in_kind;

  // Beat acceptance, substitution trigger and emit qualification
  always_comb begin
    accept  = bus.in_valid;
    subst   = accept && !bus.in_data && (zero_cnt_q == ZCNT_MAX);
    full    = (fill_q == FILL_FULL);
    emit    = accept && full;
    in_kind = KIND_ZERO;
    if (bus.in_data) begin
      in_kind = KIND_MARK;
    end else if (subst) begin
      in_kind = KIND_V;
    end
  end

  // Next delay-line contents: shift in the new entry, then apply the B rewrite
  // at its post-shift position (first zero of the run, now the oldest entry)
  always_comb begin
    line_d = {line_q[DEPTH-2:0], in_kind};
    if (subst && !parity_q) begin
      line_d[N_ZERO] = KIND_B;
    end
  end

  // Delay line, fill level, zero-run counter and mark parity
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q     <= '0;
      fill_q     <= '0;
      zero_cnt_q <= '0;
      parity_q   <= 1'b0;
    end else if (accept) begin
      line_q <= line_d;
      if (!full) begin
        fill_q <= fill_q + FW'(1);
      end
      if (bus.in_data) begin
        zero_cnt_q <= '0;
        parity_q   <= ~parity_q;
      end else if (subst) begin
        zero_cnt_q <= '0;
        parity_q   <= 1'b0;
      end else begin
        zero_cnt_q <= zero_cnt_q + ZW'(1);
      end
    end
  end

  hdbn_polarity #(
    .FIRST_POS (FIRST_POS)
  ) u_polarity (
    .clk       (clk),
    .rst       (rst),
    .emit      (emit),
    .kind      (line_q[DEPTH-1]),
    .out_valid (bus.out_valid),
    .out_code  (bus.out_code),
    .out_kind  (bus.out_kind)
  );

endmodule

// File: tb/tb_hdbn_encoder.sv
// Bench for hdbn_encoder: an N_ZERO=3 and an N_ZERO=2 instance share stimulus.
// Emitted symbols are packed as {kind, code}.
module tb_hdbn_encoder;

  logic clk;
  logic rst;

  hdbn_encoder_if bus3();
  hdbn_encoder_if bus2();

  hdbn_encoder #(.N_ZERO(3), .FIRST_POS(1)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  hdbn_encoder #(.N_ZERO(2), .FIRST_POS(1)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int illegal3 = 0;
  int illegal2 = 0;

  bit         hist[$];     // accepted bits since last reset
  logic [3:0] exp_q[$];
  logic [3:0] obs3_q[$];
  logic [3:0] obs2_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    bus3.in_valid = 1'b0;
    bus3.in_data  = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.in_data  = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    hist.delete();
    obs3_q.delete();
    obs2_q.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input bit v, input bit d);
    bus3.in_valid = v;
    bus3.in_data  = d;
    bus2.in_valid = v;
    bus2.in_data  = d;
    @(posedge clk);
    #1;
    if (v) hist.push_back(d);
  endtask

  // Feed len bits, MSB first, with up to max_gap idle cycles before each beat
  task automatic feed(input logic [15:0] bits, input int len, input int max_gap);
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, max_gap)) drive(1'b0, 1'($urandom));
      drive(1'b1, bits[len-1-i]);
    end
    drive(1'b0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus3.out_valid === 1'b1) obs3_q.push_back({bus3.out_kind, bus3.out_code});
    if ((bus3.out_valid !== 1'b1 && {bus3.out_kind, bus3.out_code} !== 4'h0) ||
        bus3.out_code === 2'b10) illegal3++;
    if (bus2.out_valid === 1'b1) obs2_q.push_back({bus2.out_kind, bus2.out_code});
    if ((bus2.out_valid !== 1'b1 && {bus2.out_kind, bus2.out_code} !== 4'h0) ||
        bus2.out_code === 2'b10) illegal2++;
  end

  // ---------------- reference model ----------------
  // Encode the whole accepted history with array rewrites, then walk it
  // assigning +1/-1 polarity; only entries already pushed out are expected.
  task automatic build_exp(input int n, input int fp);
    logic [1:0] kind[$];
    int run;
    bit par;
    int last;
    int n_out;
    logic [1:0] code;
    exp_q.delete();
    run = 0;
    par = 1'b0;
    for (int i = 0; i < hist.size(); i++) begin
      if (hist[i]) begin
        kind.push_back(2'b01);
        par = ~par;
        run = 0;
      end else begin
        run++;
        if (run == n + 1) begin
          kind.push_back(2'b11);
          if (!par) kind[i-n] = 2'b10;
          par = 1'b0;
          run = 0;
        end else begin
          kind.push_back(2'b00);
        end
      end
    end
    last  = (fp != 0) ? -1 : 1;
    n_out = kind.size() - (n + 1);
    for (int i = 0; i < n_out; i++) begin
      if (kind[i] == 2'b00) begin
        code = 2'b00;
      end else begin
        if (kind[i] != 2'b11) last = -last;
        code = (last > 0) ? 2'b01 : 2'b11;
      end
      exp_q.push_back({kind[i], code});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0);
      n_checks++;
      if ({bus3.out_valid, bus3.out_code, bus3.out_kind} !== 5'b0) begin
        $display("FAIL reset_idle3 cyc=%0d got=%b exp=00000", c,
                 {bus3.out_valid, bus3.out_code, bus3.out_kind});
      end else n_pass++;
      n_checks++;
      if ({bus2.out_valid, bus2.out_code, bus2.out_kind} !== 5'b0) begin
        $display("FAIL reset_idle2 cyc=%0d got=%b exp=00000", c,
                 {bus2.out_valid, bus2.out_code, bus2.out_kind});
      end else n_pass++;
    end
  endtask

  task automatic test_odd_parity();
    apply_reset();
    feed(16'b1_0000_1111, 9, 0);
    exp_q = {4'h5, 4'h0, 4'h0, 4'h0, 4'hD};
    n_checks++;
    if (obs3_q.size() !== exp_q.size()) $display("FAIL odd_count got=%0d exp=%0d", obs3_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs3_q.size() || obs3_q[i] !== exp_q[i]) $display("FAIL odd_sym%0d got=%h exp=%h", i, (i < obs3_q.size()) ? obs3_q[i] : 4'hx, exp_q[i]);
      else n_pass++;
    end
    build_exp(2, 1);
    n_checks++;
    if (obs2_q !== exp_q) $display("FAIL odd_n2 got=%p exp=%p", obs2_q, exp_q);
    else n_pass++;
  endtask

  task automatic test_even_parity(input int max_gap);
    apply_reset();
    feed(16'b11_0000_1111, 10, max_gap);
    exp_q = {4'h5, 4'h7, 4'h9, 4'h0, 4'h0, 4'hD};
    n_checks++;
    if (obs3_q.size() !== hist.size() - 4) $display("FAIL even_count gap=%0d got=%0d exp=%0d", max_gap, obs3_q.size(), hist.size() - 4);
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs3_q.size() || obs3_q[i] !== exp_q[i]) $display("FAIL even_sym%0d gap=%0d got=%h exp=%h", i, max_gap, (i < obs3_q.size()) ? obs3_q[i] : 4'hx, exp_q[i]);
      else n_pass++;
    end
    build_exp(2, 1);
    n_checks++;
    if (obs2_q !== exp_q) $display("FAIL even_n2 gap=%0d got=%p exp=%p", max_gap, obs2_q, exp_q);
    else n_pass++;
  endtask

  task automatic test_eight_zeros();
    apply_reset();
    feed(16'b0000_0000_1111, 12, 0);
    exp_q = {4'h9, 4'h0, 4'h0, 4'hD, 4'hB, 4'h0, 4'h0, 4'hF};
    n_checks++;
    if (obs3_q.size() !== exp_q.size()) $display("FAIL zeros8_count got=%0d exp=%0d", obs3_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs3_q.size() || obs3_q[i] !== exp_q[i]) $display("FAIL zeros8_sym%0d got=%h exp=%h", i, (i < obs3_q.size()) ? obs3_q[i] : 4'hx, exp_q[i]);
      else n_pass++;
    end
    build_exp(2, 1);
    n_checks++;
    if (obs2_q !== exp_q) $display("FAIL zeros8_n2 got=%p exp=%p", obs2_q, exp_q);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    feed(16'b000, 3, 0);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus3.out_valid, bus3.out_code, bus3.out_kind} !== 5'b0 ||
        {bus2.out_valid, bus2.out_code, bus2.out_kind} !== 5'b0) begin
      $display("FAIL midrst_out got3=%b got2=%b exp=00000",
               {bus3.out_valid, bus3.out_code, bus3.out_kind}, {bus2.out_valid, bus2.out_code, bus2.out_kind});
    end else n_pass++;
    hist.delete();
    obs3_q.delete();
    obs2_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    feed(16'b0_1111_1111, 9, 0);
    exp_q = {4'h0, 4'h5, 4'h7, 4'h5, 4'h7};
    n_checks++;
    if (obs3_q !== exp_q) $display("FAIL midrst_seq got=%p exp=%p", obs3_q, exp_q);
    else n_pass++;
    build_exp(2, 1);
    n_checks++;
    if (obs2_q !== exp_q) $display("FAIL midrst_n2 got=%p exp=%p", obs2_q, exp_q);
    else n_pass++;
  endtask

  task automatic test_n2();
    apply_reset();
    feed(16'b1000_111, 7, 0);
    exp_q = {4'h5, 4'h0, 4'h0, 4'hD};
    n_checks++;
    if (obs2_q !== exp_q) $display("FAIL n2_seq got=%p exp=%p", obs2_q, exp_q);
    else n_pass++;
    build_exp(3, 1);
    n_checks++;
    if (obs3_q !== exp_q) $display("FAIL n2_on_n3 got=%p exp=%p", obs3_q, exp_q);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      for (int b = 0; b < 150; b++) begin
        if ($urandom_range(0, 3) == 0) drive(1'b0, 1'($urandom));
        drive(1'b1, ($urandom_range(0, 3) == 0));
      end
      drive(1'b0, 1'b0);
      build_exp(3, 1);
      n_checks++;
      if (obs3_q.size() !== exp_q.size()) $display("FAIL rand3_count r=%0d got=%0d exp=%0d", r, obs3_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (i >= obs3_q.size() || obs3_q[i] !== exp_q[i]) $display("FAIL rand3_sym r=%0d i=%0d got=%h exp=%h", r, i, (i < obs3_q.size()) ? obs3_q[i] : 4'hx, exp_q[i]);
        else n_pass++;
      end
      build_exp(2, 1);
      n_checks++;
      if (obs2_q.size() !== exp_q.size()) $display("FAIL rand2_count r=%0d got=%0d exp=%0d", r, obs2_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (i >= obs2_q.size() || obs2_q[i] !== exp_q[i]) $display("FAIL rand2_sym r=%0d i=%0d got=%h exp=%h", r, i, (i < obs2_q.size()) ? obs2_q[i] : 4'hx, exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_legality();
    n_checks++;
    if (illegal3 !== 0) $display("FAIL legal3 got=%0d exp=0", illegal3);
    else n_pass++;
    n_checks++;
    if (illegal2 !== 0) $display("FAIL legal2 got=%0d exp=0", illegal2);
    else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b0;
    test_reset();
    test_odd_parity();
    test_even_parity(0);
    test_eight_zeros();
    test_even_parity(2);
    test_mid_reset();
    test_n2();
    test_random();
    test_legality();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
